// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: arbiter states, frame-timing defaults, port indices
// and the two-port arbitration pick.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SEND,
        IFG
    } arb_state_t;

    localparam int unsigned ETH_IFG_DEFAULT       = 12;
    localparam int unsigned ETH_MAX_FRAME_DEFAULT = 1600;

    localparam logic PORT_ARP = 1'b0;
    localparam logic PORT_UDP = 1'b1;

    // On contention the priority pointer decides in round-robin mode, otherwise ARP wins.
    function automatic logic arb_pick(input logic req0, input logic req1,
                                      input logic prio, input logic rr);
        logic win;
        if (req0 && req1) begin
            win = rr ? prio : PORT_ARP;
        end else if (req1) begin
            win = PORT_UDP;
        end else begin
            win = PORT_ARP;
        end
        return win;
    endfunction

endpackage

// File: rtl/gmii_tx_arb.sv
// Two-port GMII transmit arbiter: grants one frame generator at a time, forwards its
// bytes through one register stage, enforces the IFG and aborts stalled/runaway ports.
module gmii_tx_arb
    import eth_pkg::*;
#(
    parameter int unsigned IFG_CYCLES       = ETH_IFG_DEFAULT,
    parameter int unsigned GRANT_TIMEOUT    = 64,
    parameter int unsigned MAX_FRAME_CYCLES = ETH_MAX_FRAME_DEFAULT,
    parameter int unsigned ROUND_ROBIN      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       port0_req,
    input  logic       port0_tx_en,
    input  logic [7:0] port0_txd,
    output logic       port0_sel,
    input  logic       port1_req,
    input  logic       port1_tx_en,
    input  logic [7:0] port1_txd,
    output logic       port1_sel,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       arb_busy,
    output logic [7:0] abort_cnt
);

    localparam int unsigned WAIT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int unsigned FRM_W  = $clog2(MAX_FRAME_CYCLES + 1);

    arb_state_t        state_q, state_d;
    logic              cur_q, cur_d;
    logic              prio_q, prio_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic [7:0]        ifg_q, ifg_d;
    logic [7:0]        abort_q, abort_d;
    logic              sel0_q, sel0_d;
    logic              sel1_q, sel1_d;
    logic              en_q, en_d;
    logic [7:0]        txd_q, txd_d;

    logic              req_cur, en_cur, win, abort_inc;
    logic [7:0]        txd_cur;

    always_comb begin
        req_cur   = cur_q ? port1_req   : port0_req;
        en_cur    = cur_q ? port1_tx_en : port0_tx_en;
        txd_cur   = cur_q ? port1_txd   : port0_txd;
        win       = arb_pick(port0_req, port1_req, prio_q, ROUND_ROBIN != 0);

        state_d   = state_q;
        cur_d     = cur_q;
        prio_d    = prio_q;
        wait_d    = wait_q;
        frame_d   = frame_q;
        ifg_d     = ifg_q;
        sel0_d    = 1'b0;
        sel1_d    = 1'b0;
        en_d      = 1'b0;
        txd_d     = '0;
        abort_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (port0_req || port1_req) begin
                    cur_d   = win;
                    state_d = GRANT;
                    wait_d  = '0;
                    sel0_d  = !win;
                    sel1_d  = win;
                    if (ROUND_ROBIN != 0) begin
                        prio_d = !win;
                    end
                end
            end
            GRANT: begin
                sel0_d = !cur_q;
                sel1_d = cur_q;
                if (en_cur) begin
                    // The byte that arrives with tx_en is already part of the frame.
                    state_d = SEND;
                    en_d    = 1'b1;
                    txd_d   = txd_cur;
                    frame_d = FRM_W'(1);
                end else if (!req_cur) begin
                    state_d = IDLE;
                    sel0_d  = 1'b0;
                    sel1_d  = 1'b0;
                end else if (wait_q == WAIT_W'(GRANT_TIMEOUT - 1)) begin
                    state_d   = IFG;
                    ifg_d     = '0;
                    sel0_d    = 1'b0;
                    sel1_d    = 1'b0;
                    abort_inc = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            SEND: begin
                if (!en_cur || frame_q == FRM_W'(MAX_FRAME_CYCLES)) begin
                    state_d   = IFG;
                    ifg_d     = '0;
                    abort_inc = en_cur;
                end else begin
                    sel0_d  = !cur_q;
                    sel1_d  = cur_q;
                    en_d    = 1'b1;
                    txd_d   = txd_cur;
                    frame_d = frame_q + 1'b1;
                end
            end
            IFG: begin
                if (ifg_q == 8'(IFG_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        abort_d = (abort_inc && abort_q != 8'hFF) ? abort_q + 1'b1 : abort_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= PORT_ARP;
            prio_q  <= PORT_ARP;
            wait_q  <= '0;
            frame_q <= '0;
            ifg_q   <= '0;
            abort_q <= '0;
            sel0_q  <= 1'b0;
            sel1_q  <= 1'b0;
            en_q    <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            prio_q  <= prio_d;
            wait_q  <= wait_d;
            frame_q <= frame_d;
            ifg_q   <= ifg_d;
            abort_q <= abort_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            en_q    <= en_d;
            txd_q   <= txd_d;
        end
    end

    assign port0_sel  = sel0_q;
    assign port1_sel  = sel1_q;
    assign gmii_tx_en = en_q;
    assign gmii_txd   = txd_q;
    assign arb_busy   = (state_q != IDLE);
    assign abort_cnt  = abort_q;

endmodule
